// File: rtl/clk_div_monitor.sv
// clk_div_monitor
//   Measures the high and low phase lengths of a divided clock in reference
//   clock cycles and checks each completed period against the programmed
//   division ratio. The block reports lock, sticky mismatch and sticky
//   timeout status.
//
// Parameters
//   ratio_width : width of the ratio and count fields (minimum 2)
//   lock_count  : number of consecutive matching periods needed for lock (>= 1)
//
// Ports
//   i_ref_clk    : reference clock, the only clock of the block
//   i_rst_n      : synchronous active-low reset
//   i_mon_en     : monitor enable; 0 idles the block and clears its status
//   i_div_clk    : divided clock under test, synchronous to i_ref_clk
//   i_exp_ratio  : expected division ratio N
//   o_high_cnt   : high-phase length of the last completed period
//   o_low_cnt    : low-phase length of the last completed period
//   o_meas_ratio : o_high_cnt + o_low_cnt of the last completed period
//   o_meas_valid : one-cycle pulse when a new measurement is latched
//   o_locked     : lock_count consecutive matching periods were seen
//   o_mismatch   : sticky, a completed period failed the check
//   o_timeout    : sticky, a phase or period exceeded the count range
module clk_div_monitor #(
  parameter int ratio_width = 4,
  parameter int lock_count  = 2
) (
  input  logic                   i_ref_clk,
  input  logic                   i_rst_n,
  input  logic                   i_mon_en,
  input  logic                   i_div_clk,
  input  logic [ratio_width-1:0] i_exp_ratio,
  output logic [ratio_width-1:0] o_high_cnt,
  output logic [ratio_width-1:0] o_low_cnt,
  output logic [ratio_width-1:0] o_meas_ratio,
  output logic                   o_meas_valid,
  output logic                   o_locked,
  output logic                   o_mismatch,
  output logic                   o_timeout
);

  localparam int mcnt_w = $clog2(lock_count + 1);

  localparam logic [ratio_width-1:0] cnt_max  = {ratio_width{1'b1}};
  localparam logic [ratio_width-1:0] cnt_one  = ratio_width'(1);
  localparam logic [mcnt_w-1:0]      lock_lim = mcnt_w'(lock_count);
  localparam logic [mcnt_w-1:0]      mcnt_one = mcnt_w'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  // Expected high phase for ratio n: the shorter half.
  function automatic logic [ratio_width-1:0] exp_high(input logic [ratio_width-1:0] n);
    exp_high = {1'b0, n[ratio_width-1:1]};
  endfunction

  // Expected low phase for ratio n: gets the extra cycle when n is odd.
  function automatic logic [ratio_width-1:0] exp_low(input logic [ratio_width-1:0] n);
    exp_low = n - exp_high(n);
  endfunction

  state_t                 state_q;
  logic                   prev_q;
  logic [ratio_width-1:0] exp_q;
  logic [ratio_width-1:0] hcnt_q;
  logic [ratio_width-1:0] lcnt_q;
  logic [mcnt_w-1:0]      match_q;
  logic [ratio_width-1:0] high_q;
  logic [ratio_width-1:0] low_q;
  logic [ratio_width-1:0] ratio_q;
  logic                   valid_q;
  logic                   locked_q;
  logic                   mismatch_q;
  logic                   timeout_q;

  logic                   rise_s;
  logic                   fall_s;
  logic [ratio_width:0]   sum_s;
  logic                   complete_s;
  logic                   tmo_s;
  logic                   chk_en_s;
  logic                   shape_ok_s;
  logic [mcnt_w-1:0]      match_inc_s;

  // Edge detection, period arithmetic and overflow / check decisions.
  always_comb begin
    rise_s      = i_div_clk & ~prev_q;
    fall_s      = ~i_div_clk & prev_q;
    sum_s       = {1'b0, hcnt_q} + {1'b0, lcnt_q};
    complete_s  = (state_q == LOW) & rise_s;
    // A phase that is already at full count and does not end would need one
    // more count; a completed period whose sum does not fit is also rejected.
    tmo_s       = ((state_q == HIGH) & ~fall_s & (hcnt_q == cnt_max))
                | ((state_q == LOW)  & ~rise_s & (lcnt_q == cnt_max))
                | (complete_s & (sum_s > {1'b0, cnt_max}));
    // Ratios 0 and 1 cannot describe a real divided clock: no checking.
    chk_en_s    = |exp_q[ratio_width-1:1];
    shape_ok_s  = (hcnt_q == exp_high(exp_q)) & (lcnt_q == exp_low(exp_q));
    match_inc_s = (match_q == lock_lim) ? match_q : (match_q + mcnt_one);
  end

  // Measurement FSM with all status and result registers.
  always_ff @(posedge i_ref_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      prev_q     <= 1'b0;
      exp_q      <= '0;
      hcnt_q     <= '0;
      lcnt_q     <= '0;
      match_q    <= '0;
      high_q     <= '0;
      low_q      <= '0;
      ratio_q    <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      mismatch_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      prev_q  <= i_div_clk;
      valid_q <= 1'b0;
      if (!i_mon_en) begin
        // Results hold; status clears. Tracking the ratio here means that
        // enabling never sees a stale value as a ratio change.
        state_q    <= IDLE;
        exp_q      <= i_exp_ratio;
        match_q    <= '0;
        locked_q   <= 1'b0;
        mismatch_q <= 1'b0;
        timeout_q  <= 1'b0;
      end else if (i_exp_ratio != exp_q) begin
        // New ratio: restart from a clean period, keep the mismatch history.
        state_q  <= SYNC;
        exp_q    <= i_exp_ratio;
        match_q  <= '0;
        locked_q <= 1'b0;
      end else if (tmo_s) begin
        state_q   <= SYNC;
        match_q   <= '0;
        locked_q  <= 1'b0;
        timeout_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= SYNC;
          end
          SYNC: begin
            if (rise_s) begin
              hcnt_q  <= cnt_one;
              state_q <= HIGH;
            end
          end
          HIGH: begin
            if (fall_s) begin
              lcnt_q  <= cnt_one;
              state_q <= LOW;
            end else begin
              hcnt_q <= hcnt_q + cnt_one;
            end
          end
          LOW: begin
            if (rise_s) begin
              high_q  <= hcnt_q;
              low_q   <= lcnt_q;
              ratio_q <= sum_s[ratio_width-1:0];
              valid_q <= 1'b1;
              // The completing rise is also the first high cycle of the next period.
              hcnt_q  <= cnt_one;
              state_q <= HIGH;
              if (chk_en_s) begin
                if (shape_ok_s) begin
                  match_q  <= match_inc_s;
                  locked_q <= (match_inc_s == lock_lim);
                end else begin
                  match_q    <= '0;
                  locked_q   <= 1'b0;
                  mismatch_q <= 1'b1;
                end
              end
            end else begin
              lcnt_q <= lcnt_q + cnt_one;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign o_high_cnt   = high_q;
  assign o_low_cnt    = low_q;
  assign o_meas_ratio = ratio_q;
  assign o_meas_valid = valid_q;
  assign o_locked     = locked_q;
  assign o_mismatch   = mismatch_q;
  assign o_timeout    = timeout_q;

endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

- Measures the divided clock produced by the team's integer clock divider, in `i_ref_clk` cycles, and checks it against the programmed division ratio.
- `i_div_clk` is the divider's registered output, synchronous to `i_ref_clk`, so no synchronizer is needed.
- Reports per-period high count, low count and ratio, plus lock, mismatch and timeout status for configuration/BIST logic.

## Interface
- `ratio_width`, default 4: width of ratio and count fields; max measurable ratio and phase is 2^ratio_width−1.
- `lock_count`, default 2: consecutive matching periods required to assert lock (≥1).
- `i_ref_clk` in 1: reference clock; the single clock of the block.
- `i_rst_n` in 1: reset, synchronous, active-low; sampled on `i_ref_clk` rising edge.
- `i_mon_en` in 1: monitor enable.
- `i_div_clk` in 1: divided clock under test, sampled each `i_ref_clk` edge.
- `i_exp_ratio` in ratio_width: expected division ratio.
- `o_high_cnt` out ratio_width: high-phase length of the last completed period.
- `o_low_cnt` out ratio_width: low-phase length of the last completed period.
- `o_meas_ratio` out ratio_width: `o_high_cnt + o_low_cnt` of the last completed period.
- `o_meas_valid` out 1: one-cycle pulse; new measurement latched.
- `o_locked` out 1: `lock_count` consecutive matching periods seen.
- `o_mismatch` out 1: sticky; a completed period failed the check.
- `o_timeout` out 1: sticky; a phase or period exceeded the count range.

## Operation
- Internal signals: `prev` = `i_div_clk` sampled last cycle; `exp_q` = registered `i_exp_ratio`.
- Rise = `i_div_clk`=1 && `prev`=0. Fall = `i_div_clk`=0 && `prev`=1.
- States:
  - IDLE: entered on reset or `i_mon_en`=0. Leaves to SYNC when `i_mon_en`=1.
  - SYNC: discards the partial period. On rise: `hcnt`=1, go to HIGH.
  - HIGH: while `i_div_clk`=1, `hcnt`++. On fall: `lcnt`=1, go to LOW.
  - LOW: while `i_div_clk`=0, `lcnt`++. On rise, the period completes:
    - latch `o_high_cnt`=`hcnt`, `o_low_cnt`=`lcnt`, `o_meas_ratio`=`hcnt`+`lcnt`;
    - pulse `o_meas_valid`;
    - set `hcnt`=1 and stay in HIGH for the next period.
- Expected shape for N=`exp_q`: high = N>>1; low = N−(N>>1). For odd N the low phase is the longer one.
- Period check, performed at completion:
  - Match: `hcnt`==N>>1 and `lcnt`==N−(N>>1).
  - Match: increment the match counter, saturating at `lock_count`. `o_locked`=1 when it reaches `lock_count`.
  - Mismatch: clear the match counter, `o_locked`=0, `o_mismatch`=1 (sticky).
- N<2 disables checking: measurement continues, `o_locked` stays 0, `o_mismatch` is never set.
- Timeout, go to SYNC:
  - Trigger: `hcnt` or `lcnt` equals 2^ratio_width−1 and the same phase continues, or `hcnt`+`lcnt` > 2^ratio_width−1 at completion.
  - Actions: `o_timeout`=1 (sticky), match counter cleared, `o_locked`=0, no `o_meas_valid`.
- `i_exp_ratio` change: when `i_exp_ratio` ≠ `exp_q` while enabled:
  - `exp_q` updates;
  - match counter cleared, `o_locked`=0;
  - go to SYNC; `o_mismatch` unaffected.
- `i_mon_en`=0:
  - go to IDLE;
  - clear `o_locked`, `o_mismatch`, `o_timeout` and the match counter;
  - `o_high_cnt`, `o_low_cnt`, `o_meas_ratio` hold their values.
- Arithmetic: the sum is computed at ratio_width+1 bits. The stored ratio is always ≤ 2^ratio_width−1 because overflow is a timeout.

## Timing
- Reset (`i_rst_n`=0 at an edge): all outputs 0, `prev`=0, `exp_q`=0, state IDLE, counters 0.
  - Reset overrides every other input.
  - Mid-measurement reset discards the partial period.
- Latency: `o_meas_valid`, the count outputs, `o_locked` and `o_mismatch` all update on the edge after the edge that samples the completing rise.
- Timeout latency: `o_timeout` asserts on the edge after the edge that samples the overflowing cycle.
- Back-to-back: for a ratio-N clock, `o_meas_valid` pulses every N cycles; the minimum spacing is 2 cycles (N=2).
- Simultaneous events:
  - `i_mon_en` falling with a completing rise: the disable wins, no pulse.
  - `i_exp_ratio` change with a completing rise: the change wins, no pulse and no check.
- The first `o_meas_valid` after enable comes at the earliest on the second sampled rise.

## Test plan
1. `exp`=4; `i_div_clk` 2 high / 2 low.
   - `o_meas_valid` every 4 cycles with high=2, low=2, ratio=4.
   - `o_locked`=1 after the 2nd pulse.
   - `o_mismatch`=0.
2. `exp`=5; 3 low / 2 high.
   - Every period reports high=2, low=3, ratio=5.
   - `o_locked`=1 after 2 periods.
3. `exp`=5; 3 high / 2 low.
   - Ratio=5, `o_mismatch`=1, `o_locked`=0.
   - Drop `i_mon_en` for 1 cycle: `o_mismatch` clears, counts hold.
4. `i_div_clk` stuck high for 20 cycles after a rise.
   - `o_timeout`=1 on the edge after the 16th high sample.
   - No `o_meas_valid`.
   - Resume a 6-cycle clock: valid ratio=6, `o_timeout` stays 1.
5. Locked at `exp`=4, then change `exp` to 6 with a matching 6-cycle clock.
   - `o_locked`=0 the next cycle.
   - Relocks after 2 ratio-6 periods.
6. `i_rst_n`=0 mid-HIGH phase.
   - All outputs 0 at the next edge.
   - After release, the first valid arrives only after SYNC plus one full period.
